l2_queue_drain: RTL and testbench

// Pop-side consumer of the L2 request queue: acts as the DRAM model. Pops one request at a time,

---
 rtl/l2_queue_drain_if.sv | 35 +++
 rtl/l2_queue_drain.sv | 164 ++++++++++++++++
 tb/tb_l2_queue_drain.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_queue_drain_if.sv
// Queue-pop and response port bundle between the L2 request queue/fill path and the DRAM model.
interface l2_queue_drain_if #(
    parameter int unsigned REQUEST_SIZE = 38,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32
);
    // Queue side
    logic                    empty;
    logic                    valid_output;
    logic [REQUEST_SIZE-1:0] buf_out;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    pop_en;
    // Response side
    logic                    resp_valid;
    logic                    resp_ready;
    logic [ADDR_WIDTH-1:0]   resp_addr;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic [3:0]              resp_id;
    logic                    resp_is_wr;
    // Status
    logic                    busy;
    logic                    err;

    // Drain (DRAM model) side
    modport master (
        input  empty, valid_output, buf_out, dout, resp_ready,
        output pop_en, resp_valid, resp_addr, resp_data, resp_id, resp_is_wr, busy, err
    );

    // Queue + response consumer side
    modport slave (
        output empty, valid_output, buf_out, dout, resp_ready,
        input  pop_en, resp_valid, resp_addr, resp_data, resp_id, resp_is_wr, busy, err
    );
endinterface

// File: rtl/l2_queue_drain.sv
// DRAM model draining the L2 request queue: one request at a time, fixed latency, one response each.
module l2_queue_drain #(
    parameter int unsigned REQUEST_SIZE  = 38,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_DEPTH_BIT = 10,
    parameter int unsigned RD_LATENCY    = 4,
    parameter int unsigned WR_LATENCY    = 2,
    parameter int unsigned POP_TIMEOUT   = 3
) (
    input logic               clk,
    input logic               rst,
    l2_queue_drain_if.master  bus
);
    localparam int unsigned ID_WIDTH  = REQUEST_SIZE - ADDR_WIDTH - 2;
    localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_BIT;
    localparam int unsigned LAT_MAX   = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CNT_MAX   = (LAT_MAX > POP_TIMEOUT) ? LAT_MAX : POP_TIMEOUT;
    localparam int unsigned CNT_WIDTH = $clog2(CNT_MAX + 1);
    localparam logic [1:0]  OP_RD     = 2'b00;
    localparam logic [1:0]  OP_ILL    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_POP, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              op_q, op_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    pop_en_q, pop_en_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [ADDR_WIDTH-1:0]   resp_addr_q, resp_addr_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic [ID_WIDTH-1:0]     resp_id_q, resp_id_d;
    logic                    resp_is_wr_q, resp_is_wr_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];
    logic [MEM_DEPTH_BIT-1:0] mem_idx_c;
    logic                     mem_we_c;

    // Next-state, request capture, memory access and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        op_d         = op_q;
        id_d         = id_q;
        wdata_d      = wdata_q;
        resp_addr_d  = resp_addr_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_is_wr_d = resp_is_wr_q;
        err_d        = err_q;
        mem_we_c     = 1'b0;
        mem_idx_c    = addr_q[MEM_DEPTH_BIT+1:2];

        unique case (state_q)
            S_IDLE: begin
                if (!bus.empty) state_d = S_POP;
            end
            S_POP: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.valid_output) begin
                    addr_d  = bus.buf_out[ADDR_WIDTH-1:0];
                    op_d    = bus.buf_out[ADDR_WIDTH+1:ADDR_WIDTH];
                    id_d    = bus.buf_out[ADDR_WIDTH+2 +: ID_WIDTH];
                    wdata_d = bus.dout;
                    if (bus.buf_out[ADDR_WIDTH+1:ADDR_WIDTH] == OP_ILL) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = (bus.buf_out[ADDR_WIDTH+1:ADDR_WIDTH] == OP_RD)
                                  ? CNT_WIDTH'(RD_LATENCY) : CNT_WIDTH'(WR_LATENCY);
                        state_d = S_ACCESS;
                    end
                end else if (cnt_q == CNT_WIDTH'(POP_TIMEOUT - 1)) begin
                    // Entry never showed up: retry while the queue still holds something
                    cnt_d   = '0;
                    state_d = bus.empty ? S_IDLE : S_POP;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    resp_addr_d  = addr_q;
                    resp_id_d    = id_q;
                    resp_is_wr_d = (op_q != OP_RD);
                    if (op_q == OP_RD) begin
                        resp_data_d = mem[mem_idx_c];
                    end else begin
                        resp_data_d = wdata_q;
                        mem_we_c    = 1'b1;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) state_d = bus.empty ? S_IDLE : S_POP;
            end
            default: state_d = S_IDLE;
        endcase

        pop_en_d     = (state_d == S_POP);
        resp_valid_d = (state_d == S_RESP);
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            op_q         <= '0;
            id_q         <= '0;
            wdata_q      <= '0;
            pop_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_is_wr_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            id_q         <= id_d;
            wdata_q      <= wdata_d;
            pop_en_q     <= pop_en_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_is_wr_q <= resp_is_wr_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    // Word memory; contents survive reset, and a reset on the commit edge cancels the write
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) mem[mem_idx_c] <= wdata_q;
    end

    assign bus.pop_en     = pop_en_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_addr  = resp_addr_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_is_wr = resp_is_wr_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_l2_queue_drain.sv
// Bench for l2_queue_drain: queue/consumer emulation, transaction-level reference model, per-cycle compare.
module tb_l2_queue_drain;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 2;
    localparam int TMO    = 3;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  op;
        logic [3:0]  id;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  id;
        logic        is_wr;
        int          lat;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_queue_drain_if bus ();
    l2_queue_drain dut (.clk(clk), .rst(rst), .bus(bus));

    req_t        pending[$];
    rsp_t        expq[$];
    logic [31:0] mem_m [int];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, last_pop_cyc = -100, prev_pop_cyc = -100;
    int pop_count = 0, hs_count = 0, n_deliv = 0;
    bit err_m = 0, in_flight = 0, pop_seen = 0, prev_rv = 0;
    int withhold_n = 0;
    int unsigned withhold_pct = 0, force_empty_pct = 0;
    int ready_mode = 0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-cycle compare against the transaction-level model
    always @(negedge clk) begin
        rsp_t r;
        cyc++;
        if (rst) begin
            chk_eq("reset_ctrl", {bus.pop_en, bus.resp_valid, bus.resp_is_wr, bus.busy, bus.err, bus.resp_id}, '0);
            chk_eq("reset_addr_data", {bus.resp_addr, bus.resp_data}, '0);
            prev_rv      = 1'b0;
            last_pop_cyc = -100;
        end else begin
            if (prev_rv && bus.resp_ready) begin
                if (expq.size() > 0) begin
                    r = expq.pop_front();
                    if (r.is_wr) mem_m[widx(r.addr)] = r.data;
                end
                in_flight = 1'b0;
                hs_count++;
            end
            if (bus.resp_valid) begin
                chk_eq("resp_expected", 64'(expq.size()), 1);
                if (expq.size() > 0) begin
                    chk_eq("resp_addr", bus.resp_addr, expq[0].addr);
                    chk_eq("resp_data", bus.resp_data, expq[0].data);
                    chk_eq("resp_id", bus.resp_id, expq[0].id);
                    chk_eq("resp_is_wr", bus.resp_is_wr, expq[0].is_wr);
                    if (!prev_rv) chk_eq("resp_latency", 64'(cyc - last_pop_cyc), 64'(2 + expq[0].lat));
                end
            end
            if (bus.pop_en) begin
                chk_eq("pop_exclusive", {in_flight, bus.resp_valid}, 0);
                chk_eq("pop_spacing", 64'(cyc - last_pop_cyc >= 3), 1);
                prev_pop_cyc = last_pop_cyc;
                last_pop_cyc = cyc;
                pop_count++;
            end
            if (bus.pop_en || bus.resp_valid) chk_eq("busy", bus.busy, 1);
            chk_eq("err", bus.err, err_m);
            prev_rv = bus.resp_valid;
        end
    end

    task automatic push_req(input logic [31:0] a, input logic [1:0] op, input logic [3:0] id, input logic [31:0] d);
        req_t r;
        r.addr = a; r.op = op; r.id = id; r.data = d;
        pending.push_back(r);
    endtask

    // Queue hands the popped entry over; model records what the response must be
    task automatic deliver(input req_t r);
        rsp_t e;
        bus.valid_output = 1'b1;
        bus.buf_out      = {r.id, r.op, r.addr};
        bus.dout         = r.data;
        if (r.op == 2'b11) begin
            err_m = 1'b1;
        end else begin
            e.addr  = r.addr;
            e.id    = r.id;
            e.is_wr = (r.op != 2'b00);
            e.lat   = e.is_wr ? WR_LAT : RD_LAT;
            e.data  = e.is_wr ? r.data : mem_m[widx(r.addr)];
            expq.push_back(e);
            in_flight = 1'b1;
            n_deliv++;
        end
    endtask

    // One cycle of queue + consumer behaviour, driven just after the falling edge
    task automatic step();
        @(negedge clk);
        #1;
        bus.valid_output = 1'b0;
        if (pop_seen) begin
            pop_seen = 1'b0;
            if (withhold_n > 0) withhold_n--;
            else if (withhold_pct > 0 && $urandom_range(99) < withhold_pct) ;
            else if (pending.size() > 0) deliver(pending.pop_front());
        end
        if (bus.pop_en) pop_seen = 1'b1;
        bus.empty = (pending.size() == 0) ||
                    (force_empty_pct > 0 && $urandom_range(99) < force_empty_pct);
        case (ready_mode)
            0:       bus.resp_ready = 1'b1;
            1:       bus.resp_ready = 1'b0;
            default: bus.resp_ready = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst = 1'b1;
        pending.delete();
        expq.delete();
        err_m = 1'b0; in_flight = 1'b0; pop_seen = 1'b0; withhold_n = 0;
        bus.valid_output = 1'b0;
        bus.empty = 1'b1;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic wait_resp(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq({name, "_arrives"}, ok, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int pc0, hs0, d0;
        logic [31:0] a;
        logic [9:0]  ix;
        logic [1:0]  op;
        int opr;
        int wr_idx[$];

        bus.empty = 1'b1; bus.valid_output = 1'b0; bus.buf_out = '0; bus.dout = '0; bus.resp_ready = 1'b1;

        // Reset with an empty queue: nothing must be popped
        do_reset(2);
        pc0 = pop_count;
        repeat (20) step();
        chk_eq("idle_no_pop", 64'(pop_count - pc0), 0);
        chk_eq("idle_outputs", {bus.pop_en, bus.resp_valid, bus.busy, bus.err}, 0);

        // Write then read-back of the same word
        push_req(32'h0000_0040, 2'b01, 4'd3, 32'hDEAD_BEEF);
        push_req(32'h0000_0040, 2'b00, 4'd5, 32'h0);
        wait_resp("wr_ack", ok);
        if (ok) begin
            chk_eq("wr_ack_is_wr", bus.resp_is_wr, 1);
            chk_eq("wr_ack_data", bus.resp_data, 32'hDEAD_BEEF);
            chk_eq("wr_ack_id", bus.resp_id, 4'd3);
            chk_eq("wr_ack_addr", bus.resp_addr, 32'h40);
        end
        wait_resp("rd_resp", ok);
        if (ok) begin
            chk_eq("rd_is_wr", bus.resp_is_wr, 0);
            chk_eq("rd_data", bus.resp_data, 32'hDEAD_BEEF);
            chk_eq("rd_id", bus.resp_id, 4'd5);
            chk_eq("rd_latency_6", 64'(cyc - last_pop_cyc), 6);
        end

        // Entry withheld after the pop: one re-pop at timeout, single response
        step();
        withhold_n = 1;
        pc0 = pop_count; hs0 = hs_count;
        push_req(32'h0000_0040, 2'b00, 4'd1, 32'h0);
        wait_resp("retry_resp", ok);
        if (ok) chk_eq("retry_data", bus.resp_data, 32'hDEAD_BEEF);
        chk_eq("retry_pop_count", 64'(pop_count - pc0), 2);
        chk_eq("retry_pop_gap", 64'(last_pop_cyc - prev_pop_cyc), 4);
        repeat (15) step();
        chk_eq("retry_single_resp", 64'(hs_count - hs0), 1);

        // Illegal op: dropped, sticky error, next read still served
        hs0 = hs_count;
        push_req(32'h0000_0100, 2'b11, 4'd7, 32'h5555_AAAA);
        repeat (12) step();
        chk_eq("illegal_err", bus.err, 1);
        chk_eq("illegal_no_resp", 64'(hs_count - hs0), 0);
        push_req(32'h0000_0040, 2'b00, 4'd2, 32'h0);
        wait_resp("after_illegal", ok);
        if (ok) begin
            chk_eq("after_illegal_data", bus.resp_data, 32'hDEAD_BEEF);
            chk_eq("after_illegal_id", bus.resp_id, 4'd2);
        end
        chk_eq("err_sticky", bus.err, 1);

        // Consumer back-pressure: response held, no further pops
        step();
        ready_mode = 1;
        push_req(32'h0000_0040, 2'b00, 4'd4, 32'h0);
        push_req(32'h0000_0044, 2'b01, 4'd6, 32'hCAFE_F00D);
        wait_resp("stall_resp", ok);
        pc0 = pop_count;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_eq("stall_hold", {bus.resp_valid, bus.resp_data, bus.resp_id, bus.pop_en},
                   {1'b1, 32'hDEAD_BEEF, 4'd4, 1'b0});
        end
        chk_eq("stall_no_pop", 64'(pop_count - pc0), 0);
        ready_mode = 0;
        for (int i = 0; i < 10 && pop_count == pc0; i++) step();
        chk_eq("stall_release_pop", 64'(pop_count - pc0), 1);
        wait_resp("stall_next", ok);
        if (ok) begin
            chk_eq("stall_next_is_wr", bus.resp_is_wr, 1);
            chk_eq("stall_next_id", bus.resp_id, 4'd6);
        end

        // Reset on the commit edge of a write: no response, memory keeps old value
        step();
        push_req(32'h0000_0080, 2'b01, 4'd1, 32'h1234_5678);
        wait_resp("pre_abort_wr", ok);
        step();
        push_req(32'h0000_0080, 2'b01, 4'd2, 32'hBAD0_BAD0);
        for (int i = 0; i < 30 && !in_flight; i++) step();
        chk_eq("abort_delivered", in_flight, 1);
        step();
        hs0 = hs_count;
        do_reset(2);
        chk_eq("abort_no_resp", 64'(hs_count - hs0), 0);
        chk_eq("abort_err_cleared", bus.err, 0);
        push_req(32'h0000_0080, 2'b00, 4'd9, 32'h0);
        wait_resp("abort_readback", ok);
        if (ok) chk_eq("abort_mem_kept", bus.resp_data, 32'h1234_5678);
        step();

        // Randomized traffic with aliasing addresses, withheld entries, empty glitches, back-pressure
        wr_idx.push_back(widx(32'h40));
        wr_idx.push_back(widx(32'h44));
        wr_idx.push_back(widx(32'h80));
        withhold_pct = 10; force_empty_pct = 15; ready_mode = 2;
        hs0 = hs_count; d0 = n_deliv;
        for (int n = 0; n < 250; n++) begin
            opr = int'($urandom_range(99));
            if (opr < 5) op = 2'b11;
            else if (opr < 50) op = (opr % 2 == 0) ? 2'b01 : 2'b10;
            else op = 2'b00;
            if (op == 2'b00) ix = 10'(wr_idx[$urandom_range(wr_idx.size() - 1)]);
            else ix = ($urandom_range(1) != 0) ? 10'($urandom_range(1023)) : 10'($urandom_range(7));
            a = $urandom();
            a[11:2] = ix;
            if (op == 2'b01 || op == 2'b10) wr_idx.push_back(int'(ix));
            push_req(a, op, 4'($urandom_range(15)), $urandom());
            for (int g = 0; g < 400 && pending.size() >= 2; g++) step();
            repeat ($urandom_range(3)) step();
        end
        for (int g = 0; g < 3000 && !(pending.size() == 0 && expq.size() == 0 && !in_flight); g++) step();
        chk_eq("random_drain", {pending.size() == 0, expq.size() == 0, !in_flight}, 3'b111);
        chk_eq("random_resp_count", 64'(hs_count - hs0), 64'(n_deliv - d0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
